ledger_memory: RTL and testbench

- Responder end of the memory access protocol driven by the memory controller FSM: holds the coin ledger as DEPTH words of 48 bits.
- Accepts full-word or single-lane writes and registered reads.
- Models a slow memory with fixed, parameterised write and read latencies.
- Returns write_ack, read_valid and busy so the controller can sequence against real completion instead of blind wait counters.

---
 rtl/ledger_pkg.sv | 16 +
 rtl/ledger_memory_if.sv | 41 ++++
 rtl/ledger_lat_counter.sv | 26 ++
 rtl/ledger_memory.sv | 162 ++++++++++++++++
 tb/tb_ledger_memory.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ledger_pkg.sv
// Shared types and constants for the ledger memory responder.
package ledger_pkg;

  localparam int unsigned LEDGER_DATA_W = 48;
  localparam int unsigned LEDGER_LANE_W = 16;
  localparam int unsigned NUM_LANES     = LEDGER_DATA_W / LEDGER_LANE_W;

  localparam logic ACCESS_WORD = 1'b0;
  localparam logic ACCESS_LANE = 1'b1;

  typedef logic [LEDGER_DATA_W-1:0] ledger_word_t;
  typedef logic [1:0]               lane_t;

  typedef enum logic [1:0] {IDLE, WRITE, ACK, READ} mem_state_t;

endpackage

// File: rtl/ledger_memory_if.sv
// Controller <-> ledger memory access bus. Parity signals exist only when
// LEDGER_MEMORY_PARITY_EN is defined.
interface ledger_memory_if
  import ledger_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = LEDGER_DATA_W
);
  logic              write_enable;
  logic              access_type;
  lane_t             lane;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              read_req;
  logic [DATA_W-1:0] data_out;
  logic              read_valid;
  logic              write_ack;
  logic              busy;
`ifdef LEDGER_MEMORY_PARITY_EN
  logic              inject_parity;
  logic              parity_error;

  modport master (
    output write_enable, access_type, lane, address, data_in, read_req, inject_parity,
    input  data_out, read_valid, write_ack, busy, parity_error
  );
  modport slave (
    input  write_enable, access_type, lane, address, data_in, read_req, inject_parity,
    output data_out, read_valid, write_ack, busy, parity_error
  );
`else
  modport master (
    output write_enable, access_type, lane, address, data_in, read_req,
    input  data_out, read_valid, write_ack, busy
  );
  modport slave (
    input  write_enable, access_type, lane, address, data_in, read_req,
    output data_out, read_valid, write_ack, busy
  );
`endif
endinterface

// File: rtl/ledger_lat_counter.sv
// Loadable latency down-counter; o_done flags the final count of a phase.
module ledger_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (i_dec && (r_count != '0))
      r_count <= r_count - 1'b1;
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/ledger_memory.sv
// Slow ledger memory responder with fixed write/read latencies.
// Optional per-word even parity: define LEDGER_MEMORY_PARITY_EN.
module ledger_memory
  import ledger_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = LEDGER_DATA_W,
  parameter int unsigned LANE_W = LEDGER_LANE_W,
  parameter int unsigned WR_LAT = 7,
  parameter int unsigned RD_LAT = 2
) (
  input logic            clock,
  input logic            reset,
  ledger_memory_if.slave bus
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned LANES   = DATA_W / LANE_W;
  localparam int unsigned MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_type;
  lane_t             r_lane;
  logic [DATA_W-1:0] r_data_out;
  logic              r_read_valid;
  logic              r_write_ack;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_done;
  logic              w_load;
  logic              w_dec;
  logic [CNT_W-1:0]  w_value;
  logic              w_commit;
  logic              w_rdone;
  logic [DATA_W-1:0] w_new_word;

  assign w_commit = (r_state == WRITE) && w_done;
  assign w_rdone  = (r_state == READ) && w_done;

  // IDLE preloads the phase length; leaving WRITE/READ reloads zero.
  always_comb begin
    w_load  = 1'b0;
    w_dec   = 1'b0;
    w_value = '0;
    unique case (r_state)
      IDLE: begin
        w_load  = 1'b1;
        w_value = bus.write_enable ? WR_LOAD : (bus.read_req ? RD_LOAD : '0);
      end
      WRITE, READ: begin
        w_load = w_done;
        w_dec  = ~w_done;
      end
      default: ;
    endcase
  end

  ledger_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_value(w_value),
    .i_dec  (w_dec),
    .o_done (w_done)
  );

  always_comb begin
    w_new_word = r_mem[r_addr];
    if (r_type == ACCESS_WORD)
      w_new_word = r_data;
    else
      for (int unsigned l = 0; l < LANES; l++)
        if (32'(r_lane) == l)
          w_new_word[l*LANE_W +: LANE_W] = r_data[LANE_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_type       <= ACCESS_WORD;
      r_lane       <= '0;
      r_data_out   <= '0;
      r_read_valid <= 1'b0;
      r_write_ack  <= 1'b0;
      r_busy       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[ADDR_W'(i)] <= '0;
    end else begin
      r_read_valid <= 1'b0;
      r_write_ack  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.write_enable) begin
            r_addr  <= bus.address;
            r_data  <= bus.data_in;
            r_type  <= bus.access_type;
            r_lane  <= bus.lane;
            r_busy  <= 1'b1;
            r_state <= WRITE;
          end else if (bus.read_req) begin
            r_addr  <= bus.address;
            r_busy  <= 1'b1;
            r_state <= READ;
          end
        end
        WRITE: begin
          if (w_commit) begin
            r_mem[r_addr] <= w_new_word;
            r_write_ack   <= 1'b1;
            r_state       <= ACK;
          end
        end
        ACK: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        READ: begin
          if (w_rdone) begin
            r_data_out   <= r_mem[r_addr];
            r_read_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.read_valid = r_read_valid;
  assign bus.write_ack  = r_write_ack;
  assign bus.busy       = r_busy;

`ifdef LEDGER_MEMORY_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity_error <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_par[ADDR_W'(i)] <= 1'b0;
    end else begin
      r_parity_error <= 1'b0;
      if (w_commit)
        r_par[r_addr] <= (^w_new_word) ^ bus.inject_parity;
      if (w_rdone)
        r_parity_error <= (^r_mem[r_addr]) ^ r_par[r_addr];
    end
  end

  assign bus.parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_ledger_memory.sv
// Directed bench for ledger_memory with a cycle-timeline reference model.
module tb_ledger_memory;
  import ledger_pkg::*;

  localparam int WR_LAT = 7;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ledger_memory_if #(.ADDR_W(2), .DATA_W(48)) bus ();

  ledger_memory #(
    .ADDR_W(2), .DATA_W(48), .LANE_W(16), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request fixes its completion edge.
  ledger_word_t m_mem [4];
  bit           m_perr [4];
  ledger_word_t m_dout;
  bit           m_pe;
  int           cyc, busy_until, ack_at, rv_at;
  logic [1:0]   p_addr, p_lane;
  ledger_word_t p_data;
  logic         p_type;
  bit           p_inject;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_mem[i] = '0; m_perr[i] = 0; end
      m_dout = '0; m_pe = 0;
      cyc = 0; busy_until = 0; ack_at = -1; rv_at = -1;
    end else begin
      cyc++;
      if (cyc == ack_at) begin
        p_inject = 0;
`ifdef LEDGER_MEMORY_PARITY_EN
        p_inject = bus.inject_parity;
`endif
        if (!p_type)
          m_mem[p_addr] = p_data;
        else if (p_lane < 3)
          m_mem[p_addr] = (m_mem[p_addr] & ~(48'hFFFF << (16 * p_lane)))
                        | (48'(p_data[15:0]) << (16 * p_lane));
        m_perr[p_addr] = p_inject;
      end
      if (cyc == rv_at) begin
        m_dout = m_mem[p_addr];
        m_pe   = m_perr[p_addr];
      end
      if (cyc - 1 >= busy_until) begin
        if (bus.write_enable) begin
          p_addr = bus.address; p_data = bus.data_in;
          p_type = bus.access_type; p_lane = bus.lane;
          ack_at = cyc + WR_LAT; busy_until = cyc + WR_LAT + 1;
        end else if (bus.read_req) begin
          p_addr = bus.address;
          rv_at = cyc + RD_LAT; busy_until = cyc + RD_LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", bus.busy, cyc < busy_until);
      check("write_ack", bus.write_ack, cyc == ack_at);
      check("read_valid", bus.read_valid, cyc == rv_at);
      check("data_out", bus.data_out, m_dout);
`ifdef LEDGER_MEMORY_PARITY_EN
      check("parity_error", bus.parity_error, (cyc == rv_at) && m_pe);
`endif
    end
  end

  // Counts negedges after the request is driven until the pulse appears.
  task automatic wait_pulse(input string name, input bit want_ack, input int exp_n);
    int n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.write_enable = 1'b0; bus.read_req = 1'b0; end
      if (want_ack ? bus.write_ack : bus.read_valid) n = i;
    end
    check(name, n, exp_n);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [47:0] d, input logic t, input logic [1:0] l);
    bus.address = a; bus.data_in = d; bus.access_type = t; bus.lane = l;
    bus.write_enable = 1'b1;
    wait_pulse("write_ack_latency", 1'b1, WR_LAT + 1);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [47:0] exp);
    bus.address = a; bus.read_req = 1'b1;
    wait_pulse("read_latency", 1'b0, RD_LAT + 1);
    check("read_data", bus.data_out, exp);
  endtask

  initial begin
    int acks, rvs;
    bus.write_enable = 1'b0; bus.read_req = 1'b0; bus.access_type = ACCESS_WORD;
    bus.lane = '0; bus.address = '0; bus.data_in = '0;
`ifdef LEDGER_MEMORY_PARITY_EN
    bus.inject_parity = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_flags", {bus.read_valid, bus.write_ack}, 0);
    rst = 1'b0;

    do_read(2'd2, 48'h0);

    do_write(2'd1, 48'h0000_1234_5678, ACCESS_WORD, 2'd0);
    do_read(2'd1, 48'h0000_1234_5678);

    do_write(2'd0, 48'hAAAA_BBBB_CCCC, ACCESS_WORD, 2'd0);
    do_write(2'd0, 48'hFFFF_FFFF_1111, ACCESS_LANE, 2'd1);
    check("model_lane_word", m_mem[0], 48'hAAAA_1111_CCCC);
    do_read(2'd0, 48'hAAAA_1111_CCCC);
    do_write(2'd0, 48'h0000_0000_2222, ACCESS_LANE, 2'd3);
    do_read(2'd0, 48'hAAAA_1111_CCCC);
    do_write(2'd2, 48'h0000_0000_7777, ACCESS_LANE, 2'd2);
    do_read(2'd2, 48'h7777_0000_0000);

    // write and read together: write wins; read during busy is ignored
    acks = 0; rvs = 0;
    bus.address = 2'd3; bus.data_in = 48'h0000_0000_BEEF; bus.access_type = ACCESS_WORD;
    bus.write_enable = 1'b1; bus.read_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.write_enable = 1'b0; bus.read_req = 1'b0; end
      if (i == 2) begin bus.address = 2'd1; bus.read_req = 1'b1; end
      if (i == 3) bus.read_req = 1'b0;
      acks += int'(bus.write_ack);
      rvs  += int'(bus.read_valid);
    end
    check("collision_acks", acks, 1);
    check("collision_reads", rvs, 0);
    do_read(2'd3, 48'h0000_0000_BEEF);

    // write_enable held: back-to-back writes every WR_LAT+2 cycles
    acks = 0;
    bus.address = 2'd3; bus.data_in = 48'h0123_4567_89AB; bus.access_type = ACCESS_WORD;
    bus.write_enable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) bus.write_enable = 1'b0;
      acks += int'(bus.write_ack);
    end
    check("held_write_acks", acks, 3);
    do_read(2'd3, 48'h0123_4567_89AB);

    // reset in the middle of a write discards it
    acks = 0;
    bus.address = 2'd2; bus.data_in = 48'h5555_6666_7777; bus.access_type = ACCESS_WORD;
    bus.write_enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.write_enable = 1'b0;
      acks += int'(bus.write_ack);
    end
    #2 rst = 1'b1;
    #1;
    check("midwrite_reset_busy", bus.busy, 0);
    check("midwrite_reset_ack", acks + int'(bus.write_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    do_read(2'd2, 48'h0);
    do_read(2'd1, 48'h0);

`ifdef LEDGER_MEMORY_PARITY_EN
    bus.inject_parity = 1'b1;
    do_write(2'd0, 48'h0000_0000_0001, ACCESS_WORD, 2'd0);
    bus.inject_parity = 1'b0;
    do_read(2'd0, 48'h0000_0000_0001);
    check("parity_injected", bus.parity_error, 1);
    do_write(2'd1, 48'h0000_0000_0003, ACCESS_WORD, 2'd0);
    do_read(2'd1, 48'h0000_0000_0003);
    check("parity_clean", bus.parity_error, 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
